// File: rtl/fifo_read_packer_pkg.sv
// Shared constants and types for the FIFO read packer and the FIFO it drains.
// The FIFO and the packer must agree on the default word width.
package fifo_read_packer_pkg;

  localparam int PKR_FIFO_WIDTH = 16;
  localparam int PKR_PACK_RATIO = 4;

  typedef enum logic {
    FILL   = 1'b0,
    OUTPUT = 1'b1
  } pack_state_e;

  // Width of a word counter able to hold 0..ratio inclusive.
  function automatic int count_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/fifo_read_packer_if.sv
// FIFO read port, flush request and wide-beat handshake bundled into one interface.
// The packer uses the master view; the FIFO/sink environment uses the slave view.
interface fifo_read_packer_if
  import fifo_read_packer_pkg::*;
#(
  parameter int FIFO_WIDTH = PKR_FIFO_WIDTH,
  parameter int PACK_RATIO = PKR_PACK_RATIO
);

  localparam int CW = count_width(PACK_RATIO);

  logic                             fifo_rd_en;
  logic [FIFO_WIDTH-1:0]            fifo_data_out;
  logic                             fifo_empty;
  logic                             flush;
  logic [FIFO_WIDTH*PACK_RATIO-1:0] pkt_data;
  logic [CW-1:0]                    pkt_count;
  logic                             pkt_valid;
  logic                             pkt_ready;

  modport master (
    output fifo_rd_en,
    input  fifo_data_out,
    input  fifo_empty,
    input  flush,
    output pkt_data,
    output pkt_count,
    output pkt_valid,
    input  pkt_ready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_data_out,
    output fifo_empty,
    output flush,
    input  pkt_data,
    input  pkt_count,
    input  pkt_valid,
    output pkt_ready
  );

endinterface

// File: rtl/fifo_read_packer.sv
// Drains a 1-cycle-latency FIFO read port and packs PACK_RATIO words into one
// wide beat (word 0 in the LSBs); a flush emits a partial beat with its count.
module fifo_read_packer
  import fifo_read_packer_pkg::*;
#(
  parameter int FIFO_WIDTH = PKR_FIFO_WIDTH,
  parameter int PACK_RATIO = PKR_PACK_RATIO
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  fifo_read_packer_if.master bus
);

  localparam int            CW       = count_width(PACK_RATIO);
  localparam int            BW       = FIFO_WIDTH * PACK_RATIO;
  localparam logic [CW:0]   FULL_LVL = (CW+1)'(PACK_RATIO);
  localparam logic [CW-1:0] FULL_CNT = CW'(PACK_RATIO);

  pack_state_e           r_state;
  logic [CW-1:0]         r_count;
  logic                  r_inflight;
  logic                  r_flush_pending;
  logic                  r_pkt_valid;
  logic [CW-1:0]         r_pkt_count;
  logic [BW-1:0]         r_pkt_data;

  logic [CW:0]           w_level;
  logic                  w_fill;
  logic                  w_rd_en;
  logic                  w_beat_full;
  logic                  w_flush_ready;
  logic [PACK_RATIO-1:0] w_lane_we;

  // Read issue and lane decode: words already held plus the one in flight
  // must stay below a full beat, so a read is never issued without a lane.
  always_comb begin
    w_level       = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    w_fill        = (r_state == FILL);
    w_rd_en       = i_rst_n && w_fill && !bus.fifo_empty && !r_flush_pending
                    && (w_level < FULL_LVL);
    w_beat_full   = w_fill && r_inflight && (w_level == FULL_LVL);
    w_flush_ready = w_fill && r_flush_pending && !r_inflight;
    w_lane_we     = '0;
    for (int i = 0; i < PACK_RATIO; i++) begin
      w_lane_we[i] = w_fill && r_inflight && (r_count == CW'(i));
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state         <= FILL;
      r_count         <= '0;
      r_inflight      <= 1'b0;
      r_flush_pending <= 1'b0;
      r_pkt_valid     <= 1'b0;
      r_pkt_count     <= '0;
      r_pkt_data      <= '0;
    end else begin
      case (r_state)
        FILL: begin
          r_inflight <= w_rd_en;
          for (int i = 0; i < PACK_RATIO; i++) begin
            if (w_lane_we[i]) begin
              r_pkt_data[i*FIFO_WIDTH +: FIFO_WIDTH] <= bus.fifo_data_out;
            end
          end
          if (r_inflight) begin
            r_count <= r_count + CW'(1);
          end
          // A completing capture wins over any flush: one full beat, no empty tail.
          if (w_beat_full) begin
            r_state         <= OUTPUT;
            r_pkt_valid     <= 1'b1;
            r_pkt_count     <= FULL_CNT;
            r_flush_pending <= 1'b0;
          end else if (w_flush_ready) begin
            r_flush_pending <= 1'b0;
            if (r_count != '0) begin
              r_state     <= OUTPUT;
              r_pkt_valid <= 1'b1;
              r_pkt_count <= r_count;
            end
          end else if (bus.flush) begin
            r_flush_pending <= 1'b1;
          end
        end

        OUTPUT: begin
          r_inflight <= 1'b0;
          if (r_pkt_valid && bus.pkt_ready) begin
            r_state     <= FILL;
            r_pkt_valid <= 1'b0;
            r_pkt_count <= '0;
            r_pkt_data  <= '0;
            r_count     <= '0;
          end
        end

        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.pkt_valid  = r_pkt_valid;
  assign bus.pkt_data   = r_pkt_data;
  assign bus.pkt_count  = r_pkt_count;

endmodule
